// File: rtl/sub_pkg.sv
// Shared types for the pipelined borrow-lookahead subtractor.
// Each bit carries a propagate/generate/transfer triple.
package sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef struct packed {
    logic p;
    logic g;
    logic t;
  } pgt_t;

endpackage

// File: rtl/bla_slice.sv
// Combinational N-bit borrow-lookahead slice.
// Every internal borrow is a flat sum of products of g, t and bin.
module bla_slice
  import sub_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH / 2
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] dif,
  output logic         bout,
  output logic         msb_bin
);

  pgt_t [N-1:0] pgt;
  logic [N:0]   br;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      pgt[i].p = a[i] ^ b[i];
      pgt[i].g = ~a[i] & b[i];
      pgt[i].t = ~(a[i] ^ b[i]);
    end
  end

  // br[i] = OR over k<i of g_k & t_(k+1..i-1), plus bin & t_(0..i-1)
  always_comb begin
    logic acc;
    logic term;
    acc  = 1'b0;
    term = 1'b0;
    br   = '0;
    for (int i = 0; i <= N; i++) begin
      acc = bin;
      for (int j = 0; j < i; j++) begin
        acc = acc & pgt[j].t;
      end
      for (int k = 0; k < i; k++) begin
        term = pgt[k].g;
        for (int j = k + 1; j < i; j++) begin
          term = term & pgt[j].t;
        end
        acc = acc | term;
      end
      br[i] = acc;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      dif[i] = pgt[i].p ^ br[i];
    end
  end

  assign bout    = br[N];
  assign msb_bin = br[N-1];

endmodule

// File: rtl/sub8_pipe.sv
// Two-stage pipelined subtractor d = a - b - bin with valid/ready.
// Stage 1 resolves the low half, stage 2 the high half and flags.
module sub8_pipe
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int HALF = WIDTH / 2;

  if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("sub8_pipe: WIDTH must be even and >= 2");
  end

  logic            s1_valid;
  logic [HALF-1:0] s1_dlo;
  logic            s1_br;
  logic [HALF-1:0] s1_ahi;
  logic [HALF-1:0] s1_bhi;
  logic            s1_amsb;
  logic            s1_bmsb;

  logic            s2_ready;
  logic [HALF-1:0] lo_dif;
  logic            lo_bout;
  logic            lo_msb;
  logic [HALF-1:0] hi_dif;
  logic            hi_bout;
  logic            hi_msb;
  logic            hi_ovf;

  assign s2_ready = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_ready;

  bla_slice #(.N(HALF)) u_lo (
    .a       (a[HALF-1:0]),
    .b       (b[HALF-1:0]),
    .bin     (bin),
    .dif     (lo_dif),
    .bout    (lo_bout),
    .msb_bin (lo_msb)
  );

  bla_slice #(.N(HALF)) u_hi (
    .a       (s1_ahi),
    .b       (s1_bhi),
    .bin     (s1_br),
    .dif     (hi_dif),
    .bout    (hi_bout),
    .msb_bin (hi_msb)
  );

  assign hi_ovf = (s1_amsb ^ s1_bmsb) & (hi_dif[HALF-1] ^ s1_amsb);

  // Sign-rule overflow must agree with borrow-out xor msb borrow-in
  a_ovf_xchk: assert property (@(posedge clk) disable iff (!rst_n)
    hi_ovf == (hi_bout ^ hi_msb));
  a_lo_xchk: assert property (@(posedge clk) disable iff (!rst_n)
    lo_dif[HALF-1] == (a[HALF-1] ^ b[HALF-1] ^ lo_msb));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_dlo   <= '0;
      s1_br    <= 1'b0;
      s1_ahi   <= '0;
      s1_bhi   <= '0;
      s1_amsb  <= 1'b0;
      s1_bmsb  <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_dlo  <= lo_dif;
        s1_br   <= lo_bout;
        s1_ahi  <= a[WIDTH-1:HALF];
        s1_bhi  <= b[WIDTH-1:HALF];
        s1_amsb <= a[WIDTH-1];
        s1_bmsb <= b[WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      d         <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        d    <= {hi_dif, s1_dlo};
        bout <= hi_bout;
        ovf  <= hi_ovf;
      end
    end
  end

endmodule

// File: tb/tb_sub8_pipe.sv
// Scoreboard bench for sub8_pipe: driver pushes model results,
// a forked monitor compares whatever the DUT presents.
module tb_sub8_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] d;
  logic       bout;
  logic       ovf;

  typedef struct {
    logic [7:0] d;
    logic       bout;
    logic       ovf;
    int         cyc;
    bit         chk;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   accepted = 0;
  int   cyc = 0;
  bit   rnd = 1'b0;

  sub8_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)",
               name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values
  function automatic exp_t model(input logic [7:0] x,
                                 input logic [7:0] y,
                                 input logic bi,
                                 input bit ck,
                                 input int c);
    exp_t e;
    int u;
    int s;
    u = int'(x) - int'(y) - int'(bi);
    s = int'($signed(x)) - int'($signed(y)) - int'(bi);
    e.d    = u[7:0];
    e.bout = (u < 0);
    e.ovf  = (s > 127) || (s < -128);
    e.cyc  = c;
    e.chk  = ck;
    return e;
  endfunction

  task automatic rnd_ready();
    if (rnd) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rnd_ready();
    end
  endtask

  // Called and returns at posedge+1 phase
  task automatic send(input logic [7:0] x, input logic [7:0] y,
                      input logic bi, input bit ck);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    in_valid = 1'b1;
    a   = x;
    b   = y;
    bin = bi;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(x, y, bi, ck, cyc));
        accepted++;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      rnd_ready();
      n++;
      if (!done && n > 200) begin
        check("send_timeout", 32'd1, 32'd0);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q[0];
          check("d", 32'(d), 32'(e.d));
          check("bout", 32'(bout), 32'(e.bout));
          check("ovf", 32'(ovf), 32'(e.ovf));
          if (out_ready) begin
            if (e.chk) check("latency", 32'(cyc - e.cyc), 32'd2);
            void'(q.pop_front());
          end
        end
      end
    end
  endtask

  initial begin
    int c0;
    int acc0;
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    out_ready = 1'b1;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    send(8'h00, 8'h01, 1'b0, 1'b1);
    step(3);
    send(8'h80, 8'h01, 1'b0, 1'b1);
    send(8'h7F, 8'hFF, 1'b0, 1'b1);
    send(8'h35, 8'h12, 1'b1, 1'b1);
    send(8'h10, 8'h01, 1'b0, 1'b1);
    step(4);

    c0 = cyc;
    send(8'h05, 8'h03, 1'b0, 1'b1);
    send(8'hFF, 8'hFF, 1'b0, 1'b1);
    send(8'h00, 8'h00, 1'b1, 1'b1);
    send(8'h40, 8'h20, 1'b0, 1'b1);
    check("stream_cycles", 32'(cyc - c0), 32'd4);
    step(4);

    out_ready = 1'b0;
    acc0 = accepted;
    send(8'h11, 8'h22, 1'b0, 1'b0);
    send(8'h33, 8'h01, 1'b1, 1'b0);
    in_valid = 1'b1;
    a   = 8'h90;
    b   = 8'h10;
    bin = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    check("bp_accepted", 32'(accepted - acc0), 32'd2);
    out_ready = 1'b1;
    c0 = cyc;
    send(8'h90, 8'h10, 1'b0, 1'b0);
    check("bp_accept_cycles", 32'(cyc - c0), 32'd1);
    step(4);

    out_ready = 1'b0;
    send(8'h55, 8'h11, 1'b0, 1'b0);
    send(8'h66, 8'h22, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_d", 32'(d), 32'd0);
    check("arst_bout", 32'(bout), 32'd0);
    q.delete();
    step(2);
    rst_n = 1'b1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    step(3);
    check("no_stale", 32'(out_valid), 32'd0);
    send(8'h09, 8'h04, 1'b0, 1'b1);
    step(4);

    rnd = 1'b1;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) step(1);
      send(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    end
    rnd = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 100) begin
      step(1);
      n++;
    end
    check("drain_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
